// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues requests; the slave side computes and reports the result.
interface serial_sub_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;

    modport master (
        output start, a, b, bin,
        input  ready, busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output ready, busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with a single borrow flop replacing the ripple chain.
module serial_sub #(
    parameter int N = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    serial_sub_if.slave bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  res_q, res_d;
    logic          br_q, br_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          bout_q, bout_d;
    logic          ovf_q, ovf_d;

    logic          last_s;
    logic          d_bit_s;
    logic          br_next_s;

    function automatic logic diff_bit(input logic ai, input logic bi, input logic br);
        return ai ^ bi ^ br;
    endfunction

    function automatic logic borrow_next(input logic ai, input logic bi, input logic br);
        return (~ai & bi) | (~(ai ^ bi) & br);
    endfunction

    assign last_s    = (cnt_q == CW'(N - 1));
    assign d_bit_s   = diff_bit(a_q[0], b_q[0], br_q);
    assign br_next_s = borrow_next(a_q[0], b_q[0], br_q);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_RUN;
                else           state_d = S_IDLE;
            end
            S_RUN: begin
                if (last_s) state_d = S_DONE;
                else        state_d = S_RUN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state_q)
            S_IDLE:  bus.ready = 1'b1;
            S_RUN:   bus.busy  = 1'b1;
            S_DONE:  bus.done  = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    // Datapath next values; ovf uses operand MSBs, which sit in bit 0 on the last step
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;
        ovf_d  = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    br_d  = bus.bin;
                    cnt_d = {CW{1'b0}};
                    res_d = {N{1'b0}};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_RUN: begin
                a_d   = {1'b0, a_q[N-1:1]};
                b_d   = {1'b0, b_q[N-1:1]};
                br_d  = br_next_s;
                res_d = {d_bit_s, res_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_s) begin
                    diff_d = {d_bit_s, res_q[N-1:1]};
                    bout_d = br_next_s;
                    ovf_d  = (a_q[0] ^ b_q[0]) & (a_q[0] ^ d_bit_s);
                end else begin
                    diff_d = diff_q;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q    <= {N{1'b0}};
            b_q    <= {N{1'b0}};
            res_q  <= {N{1'b0}};
            br_q   <= 1'b0;
            cnt_q  <= {CW{1'b0}};
            diff_q <= {N{1'b0}};
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            br_q   <= br_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;

endmodule
